// File: rtl/debug_timestamp_fmt_if.sv
// Bus bundle for the debug timestamp formatter.
// The master side drives the controls and ch_data. The slave side returns the message and status.
interface debug_timestamp_fmt_if #(
  parameter int CTR_WIDTH   = 14,
  parameter int DIGITS      = 5,
  parameter int FRAC_DIGITS = 1,
  parameter int NUM_CH      = 2,
  parameter int CH_WIDTH    = 8,
  parameter int CH_DIGITS   = 3
);
  localparam int MSG_CHARS = DIGITS + ((FRAC_DIGITS > 0) ? 1 : 0) + NUM_CH*(1+CH_DIGITS) + 2;

  logic                         en;
  logic [NUM_CH*CH_WIDTH-1:0]   ch_data;
  logic                         tx_busy;
  logic [MSG_CHARS*8-1:0]       msg;
  logic                         msg_valid;
  logic [7:0]                   overrun;
  logic [CTR_WIDTH-1:0]         ts_out;

  modport master (output en, ch_data, tx_busy, input msg, msg_valid, overrun, ts_out);
  modport slave  (input en, ch_data, tx_busy, output msg, msg_valid, overrun, ts_out);
endinterface

// File: rtl/debug_timestamp_fmt.sv
// Free-running timestamp and per-frame channel snapshot, converted to decimal ASCII.
// Conversion uses serial double-dabble at one bit per cycle, and emission is gated by the downstream tx_busy signal.
module debug_timestamp_fmt #(
  parameter int CTR_WIDTH   = 14,
  parameter int DIGITS      = 5,
  parameter int FRAC_DIGITS = 1,
  parameter int NUM_CH      = 2,
  parameter int CH_WIDTH    = 8,
  parameter int CH_DIGITS   = 3,
  parameter int FRAME_TICKS = 40,
  parameter int WRAP        = 1
) (
  input logic                  clk_debug,
  input logic                  rst,
  debug_timestamp_fmt_if.slave bus
);
  localparam int MSG_CHARS = DIGITS + ((FRAC_DIGITS > 0) ? 1 : 0) + NUM_CH*(1+CH_DIGITS) + 2;
  localparam int CHW   = NUM_CH*CH_WIDTH;
  localparam int TSB   = DIGITS*4;
  localparam int CHB   = CH_DIGITS*4;
  localparam int FCW   = $clog2(FRAME_TICKS);
  localparam int BW    = $clog2(CTR_WIDTH + CH_WIDTH + 1);
  localparam int IW    = $clog2(NUM_CH + 1);
  localparam int TS_CH = DIGITS + ((FRAC_DIGITS > 0) ? 1 : 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONV_TS = 2'd1;
  localparam logic [1:0] CONV_CH = 2'd2;
  localparam logic [1:0] EMIT    = 2'd3;

  localparam logic [CTR_WIDTH-1:0]   TS_MAX  = '1;
  localparam logic [MSG_CHARS*8-1:0] RST_MSG = {{(MSG_CHARS-1){8'h20}}, 8'h0d};

  logic [1:0]                r_state;
  logic [CTR_WIDTH-1:0]      r_ts;
  logic [FCW-1:0]            r_fc;
  logic [CTR_WIDTH-1:0]      r_ts_bin;
  logic [TSB-1:0]            r_ts_bcd;
  logic [CHW-1:0]            r_ch_snap;
  logic [CH_WIDTH-1:0]       r_cbin;
  logic [CHB-1:0]            r_cbcd;
  logic [NUM_CH*CHB-1:0]     r_ch_bcd;
  logic [BW-1:0]             r_bit;
  logic [IW-1:0]             r_ch_idx;
  logic [1:0]                r_vld_pipe;
  logic [MSG_CHARS*8-1:0]    r_msg;
  logic [7:0]                r_overrun;

  logic [TSB-1:0]            w_ts_adj;
  logic [CHB-1:0]            w_ch_adj;
  logic [CHB-1:0]            w_cnext;
  logic [(NUM_CH+1)*CHB-1:0] w_cat;
  logic                      w_snap;
  logic [MSG_CHARS-1:0][7:0] w_chars;

  assign w_snap = bus.en && (r_fc == FCW'(FRAME_TICKS-1)) && (r_state == IDLE);

  // Add-3 correction on every digit of 5 or more, applied before each shift.
  always_comb begin
    w_ts_adj = r_ts_bcd;
    for (int d = 0; d < DIGITS; d++)
      if (r_ts_bcd[d*4 +: 4] > 4'd4) w_ts_adj[d*4 +: 4] = r_ts_bcd[d*4 +: 4] + 4'd3;
  end

  always_comb begin
    w_ch_adj = r_cbcd;
    for (int d = 0; d < CH_DIGITS; d++)
      if (r_cbcd[d*4 +: 4] > 4'd4) w_ch_adj[d*4 +: 4] = r_cbcd[d*4 +: 4] + 4'd3;
  end

  assign w_cnext = {w_ch_adj[CHB-2:0], r_cbin[CH_WIDTH-1]};
  // Finished channels are shifted in from the top, so ch0 ends up in the lowest slot.
  assign w_cat   = {w_cnext, r_ch_bcd} >> CHB;

  // Fixed character positions. Index MSG_CHARS-1 holds the first character.
  for (genvar d = 0; d < DIGITS; d++) begin : g_ts
    localparam int POS = (DIGITS-1-d) + ((FRAC_DIGITS > 0 && d < FRAC_DIGITS) ? 1 : 0);
    assign w_chars[MSG_CHARS-1-POS] = {4'h3, r_ts_bcd[d*4 +: 4]};
  end
  if (FRAC_DIGITS > 0) begin : g_dot
    assign w_chars[MSG_CHARS-1-(DIGITS-FRAC_DIGITS)] = 8'h2e;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int BASE = TS_CH + c*(1+CH_DIGITS);
    assign w_chars[MSG_CHARS-1-BASE] = 8'h20;
    for (genvar d = 0; d < CH_DIGITS; d++) begin : g_dig
      assign w_chars[MSG_CHARS-1-(BASE+CH_DIGITS-d)] = {4'h3, r_ch_bcd[c*CHB + d*4 +: 4]};
    end
  end
  assign w_chars[1] = 8'h20;
  assign w_chars[0] = 8'h0d;

  always_ff @(posedge clk_debug) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ts       <= '0;
      r_fc       <= '0;
      r_vld_pipe <= '0;
      r_overrun  <= '0;
      r_msg      <= RST_MSG;
    end else begin
      // [0] is set at the end of EMIT. [1] is msg_valid, asserted when msg loads.
      r_vld_pipe <= {r_vld_pipe[0], 1'b0};
      if (r_vld_pipe[0]) r_msg <= w_chars;

      if (bus.en) begin
        if (WRAP != 0 || r_ts != TS_MAX) r_ts <= r_ts + 1'b1;
        r_fc <= (r_fc == FCW'(FRAME_TICKS-1)) ? '0 : r_fc + 1'b1;
      end

      case (r_state)
        IDLE: if (w_snap) begin
          r_ts_bin  <= r_ts;
          r_ts_bcd  <= '0;
          r_cbin    <= bus.ch_data[CH_WIDTH-1:0];
          r_ch_snap <= bus.ch_data >> CH_WIDTH;
          r_cbcd    <= '0;
          r_bit     <= '0;
          r_ch_idx  <= '0;
          r_state   <= CONV_TS;
        end
        CONV_TS: begin
          r_ts_bcd <= {w_ts_adj[TSB-2:0], r_ts_bin[CTR_WIDTH-1]};
          r_ts_bin <= r_ts_bin << 1;
          if (r_bit == BW'(CTR_WIDTH-1)) begin
            r_bit   <= '0;
            r_state <= CONV_CH;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        CONV_CH: begin
          if (r_bit == BW'(CH_WIDTH-1)) begin
            r_bit     <= '0;
            r_cbcd    <= '0;
            r_ch_bcd  <= w_cat[NUM_CH*CHB-1:0];
            r_cbin    <= r_ch_snap[CH_WIDTH-1:0];
            r_ch_snap <= r_ch_snap >> CH_WIDTH;
            if (r_ch_idx == IW'(NUM_CH-1)) r_state <= EMIT;
            else                           r_ch_idx <= r_ch_idx + 1'b1;
          end else begin
            r_bit  <= r_bit + 1'b1;
            r_cbcd <= w_cnext;
            r_cbin <= r_cbin << 1;
          end
        end
        default: begin
          r_state <= IDLE;
          if (!bus.tx_busy)             r_vld_pipe[0] <= 1'b1;
          else if (r_overrun != 8'hff) r_overrun <= r_overrun + 1'b1;
        end
      endcase
    end
  end

  assign bus.msg       = r_msg;
  assign bus.msg_valid = r_vld_pipe[1];
  assign bus.overrun   = r_overrun;
  assign bus.ts_out    = r_ts;
endmodule

// File: tb/tb_debug_timestamp_fmt.sv
// Self-checking bench for debug_timestamp_fmt, with default parameters plus a saturating (WRAP=0) twin.
// A frame-level reference model predicts each message, the overrun count and the timestamp.
module tb_debug_timestamp_fmt;
  logic clk_debug = 1'b0;
  always #5 clk_debug = ~clk_debug;

  logic        rst, en, txb;
  logic [15:0] chd;

  debug_timestamp_fmt_if bus();
  debug_timestamp_fmt_if bus2();
  assign bus.en  = en;  assign bus.ch_data  = chd; assign bus.tx_busy  = txb;
  assign bus2.en = en;  assign bus2.ch_data = chd; assign bus2.tx_busy = txb;

  debug_timestamp_fmt dut (.clk_debug(clk_debug), .rst(rst), .bus(bus));
  debug_timestamp_fmt #(.WRAP(0)) dut2 (.clk_debug(clk_debug), .rst(rst), .bus(bus2));

  localparam logic [7:0]   CR      = 8'h0d;
  localparam logic [127:0] RST_MSG = {{15{8'h20}}, 8'h0d};

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  function automatic logic [7:0] dig(input int v, input int p);
    return 8'h30 + 8'((v / (10 ** p)) % 10);
  endfunction

  function automatic logic [127:0] fmt(input int ts, input int c0, input int c1);
    logic [7:0]   b [16];
    logic [127:0] r;
    b[0] = dig(ts,4); b[1] = dig(ts,3); b[2] = dig(ts,2); b[3] = dig(ts,1);
    b[4] = 8'h2e;     b[5] = dig(ts,0); b[6] = 8'h20;
    b[7] = dig(c0,2); b[8] = dig(c0,1); b[9] = dig(c0,0); b[10] = 8'h20;
    b[11] = dig(c1,2); b[12] = dig(c1,1); b[13] = dig(c1,0); b[14] = 8'h20; b[15] = CR;
    r = '0;
    for (int k = 0; k < 16; k++) r = {r[119:0], b[k]};
    return r;
  endfunction

  // Reference model: frame counting, and an emit decision 31 edges after each snapshot.
  int           edge_n = 0, m_ts = 0, m2_ts = 0, m_fc = 0, m_ovr = 0, n_valid = 0;
  int           m_snap_edge = 0, m_sts = 0, m_c0 = 0, m_c1 = 0;
  bit           m_pend = 0, m_fire = 0, exp_valid = 0, chk_on = 0;
  logic [127:0] m_msg = RST_MSG;

  always @(posedge clk_debug) begin
    bit idle;
    edge_n++;
    exp_valid = 0;
    if (rst) begin
      m_ts = 0; m2_ts = 0; m_fc = 0; m_pend = 0; m_fire = 0; m_ovr = 0; m_msg = RST_MSG;
    end else begin
      idle = !m_pend;
      if (m_fire) begin
        m_fire = 0; exp_valid = 1; m_msg = fmt(m_sts, m_c0, m_c1);
      end
      if (m_pend && edge_n == m_snap_edge + 31) begin
        m_pend = 0;
        if (txb) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
        else     m_fire = 1;
      end
      if (en && m_fc == 39 && idle) begin
        m_pend = 1; m_snap_edge = edge_n; m_sts = m_ts; m_c0 = int'(chd[7:0]); m_c1 = int'(chd[15:8]);
      end
      if (en) begin
        m_ts  = (m_ts + 1) % 16384;
        m2_ts = (m2_ts < 16383) ? m2_ts + 1 : 16383;
        m_fc  = (m_fc + 1) % 40;
      end
    end
    #1;
    if (bus.msg_valid) n_valid++;
    if (bus.msg_valid || exp_valid) begin
      chk("msg_valid", bus.msg_valid, exp_valid);
      chk("msg", bus.msg, m_msg);
    end
    if (chk_on) begin
      chk("ts_out", bus.ts_out, m_ts);
      chk("ts_out_sat", bus2.ts_out, m2_ts);
      chk("overrun", bus.overrun, m_ovr);
    end
  end

  task automatic wait_snap(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_debug);
      if (m_pend) return;
    end
    timeout(name);
  endtask

  task automatic wait_valid(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_debug);
      if (bus.msg_valid) return;
    end
    timeout(name);
  endtask

  typedef struct {
    logic [7:0]   c1, c0;
    logic         busy;
    logic [127:0] exp_msg;
    int           exp_ovr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int nv0, cyc;
    logic [7:0] prev_ovr;
    vecs[0] = '{8'd255, 8'd7,   1'b0, {"0003.9 007 255 ", CR}, 0};
    vecs[1] = '{8'd0,   8'd0,   1'b0, {"0007.9 000 000 ", CR}, 0};
    vecs[2] = '{8'd100, 8'd42,  1'b1, {"0007.9 000 000 ", CR}, 1};
    vecs[3] = '{8'd9,   8'd10,  1'b0, {"0015.9 010 009 ", CR}, 1};

    rst = 1'b1; en = 1'b0; txb = 1'b0; chd = '0;
    repeat (3) @(negedge clk_debug);
    chk("rst_msg", bus.msg, RST_MSG);
    chk("rst_valid", bus.msg_valid, 1'b0);
    chk("rst_overrun", bus.overrun, 8'd0);
    chk("rst_ts", bus.ts_out, 14'd0);

    rst = 1'b0; en = 1'b1;
    foreach (vecs[i]) begin
      chd = {vecs[i].c1, vecs[i].c0};
      txb = vecs[i].busy;
      prev_ovr = bus.overrun;
      for (cyc = 0; cyc < 100; cyc++) begin
        @(negedge clk_debug);
        if (bus.msg_valid || bus.overrun != prev_ovr) break;
      end
      if (cyc == 100) timeout("tbl_event");
      chk("tbl_msg", bus.msg, vecs[i].exp_msg);
      chk("tbl_overrun", bus.overrun, vecs[i].exp_ovr);
    end
    txb = 1'b0;

    // Channel values changed one cycle after the snapshot must not leak into the message.
    chd = {8'd45, 8'd123};
    wait_snap("snap_hold");
    chd = {8'd99, 8'd200};
    wait_valid("valid_hold");
    chk("ch_hold", bus.msg[79:0], {" 123 045 ", CR});

    // Freeze mid-frame while a conversion is in flight.
    wait_snap("snap_freeze");
    repeat (5) @(negedge clk_debug);
    en = 1'b0;
    nv0 = n_valid;
    repeat (100) @(negedge clk_debug);
    chk("freeze_ts", bus.ts_out, m_ts);
    chk("freeze_emit", n_valid - nv0, 1);
    en = 1'b1;

    chk_on = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_debug);
      chd = 16'($urandom);
      txb = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 7) != 0);
    end
    chk_on = 0;
    en = 1'b1;

    txb = 1'b1;
    repeat (300*40 + 40) @(negedge clk_debug);
    chk("overrun_sat", bus.overrun, 8'd255);
    chk("overrun_model", bus.overrun, m_ovr);
    txb = 1'b0;

    rst = 1'b1; @(negedge clk_debug); rst = 1'b0;
    repeat (16383) @(negedge clk_debug);
    chk("wrap_top", bus.ts_out, 14'd16383);
    chk("sat_top", bus2.ts_out, 14'd16383);
    @(negedge clk_debug);
    chk("wrap_zero", bus.ts_out, 14'd0);
    chk("sat_hold", bus2.ts_out, 14'd16383);
    repeat (12) @(negedge clk_debug);
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk_debug);
      if (bus2.msg_valid) break;
    end
    if (cyc == 100) timeout("sat_valid");
    chk("sat_msg", bus2.msg[127:80], "1638.3");

    // Reset 10 cycles into a conversion aborts it.
    wait_snap("snap_rst");
    repeat (10) @(negedge clk_debug);
    rst = 1'b1;
    @(negedge clk_debug);
    chk("abort_msg", bus.msg, RST_MSG);
    chk("abort_ts", bus.ts_out, 14'd0);
    chk("abort_ovr", bus.overrun, 8'd0);
    rst = 1'b0;
    nv0 = n_valid;
    repeat (40) @(negedge clk_debug);
    chk("abort_novalid", n_valid - nv0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
